// File: rtl/keypad_entry_ctrl.sv
// keypad_entry_ctrl: 4x4 keypad scanner with press/release debounce and
// a 3-digit entry shift register feeding the display multiplexer.
// Build option: define KEYPAD_ROW_SYNC_EN to pass row_in through a 2-flop
// synchronizer; otherwise row_in is used directly (synchronous stimulus).
//
//  state      | meaning
//  -----------+--------------------------------------------------------
//  S_SCAN     | drive one column per dwell, look for any low row
//  S_DEBOUNCE | column held, require the latched row to stay low
//  S_CAPTURE  | one cycle: shift in decoded digit or clear on invalid key
//  S_RELEASE  | column held, require all rows high before scanning again
module keypad_entry_ctrl #(
  parameter int SCAN_CNT     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [1:0] key_row,
  output logic [1:0] key_col,
  input  logic [3:0] key_bcd,
  input  logic       key_valid,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic       key_strobe
);

  localparam int CNT_MAX = (SCAN_CNT > DEBOUNCE_CNT) ? SCAN_CNT : DEBOUNCE_CNT;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_CNT - 1);
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_CAPTURE, S_RELEASE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s;
  logic [1:0]    row_low_idx;
  logic          row_any_low;
  logic          key_bit_low;
  logic          capture_en;

`ifdef KEYPAD_ROW_SYNC_EN
  logic [3:0] row_m, row_q;

  // Two-flop synchronizer; idle (all rows high) out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_m <= 4'hF;
      row_q <= 4'hF;
    end else begin
      row_m <= row_in;
      row_q <= row_m;
    end
  end

  assign row_s = row_q;
`else
  assign row_s = row_in;
`endif

  assign row_any_low = (row_s != 4'hF);
  assign key_bit_low = ~row_s[key_row];

  // Lowest-index low row wins when several rows are low at once.
  always_comb begin
    row_low_idx = 2'd0;
    if      (!row_s[0]) row_low_idx = 2'd0;
    else if (!row_s[1]) row_low_idx = 2'd1;
    else if (!row_s[2]) row_low_idx = 2'd2;
    else if (!row_s[3]) row_low_idx = 2'd3;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_SCAN;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_SCAN:     if (cnt == SCAN_LAST && row_any_low) state_nxt = S_DEBOUNCE;
      S_DEBOUNCE: if (!key_bit_low)                    state_nxt = S_SCAN;
                  else if (cnt == DB_LAST)             state_nxt = S_CAPTURE;
      S_CAPTURE:                                       state_nxt = S_RELEASE;
      S_RELEASE:  if (!row_any_low && cnt == DB_LAST)  state_nxt = S_SCAN;
      default:                                         state_nxt = S_SCAN;
    endcase
  end

  // Outputs decoded from state: one-cold column drive and capture enable.
  always_comb begin
    col_out    = ~(4'b0001 << col_idx);
    capture_en = (state == S_CAPTURE);
  end

  // Shared dwell/debounce counter, column index and latched key position.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      col_idx <= 2'd0;
      key_row <= 2'd0;
      key_col <= 2'd0;
    end else begin
      case (state)
        S_SCAN: begin
          if (cnt == SCAN_LAST) begin
            cnt <= '0;
            if (row_any_low) begin
              key_row <= row_low_idx;
              key_col <= col_idx;
            end else begin
              col_idx <= col_idx + 2'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DEBOUNCE: begin
          if (!key_bit_low) begin
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
          end else if (cnt == DB_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CAPTURE: cnt <= '0;
        S_RELEASE: begin
          if (row_any_low) begin
            cnt <= '0;
          end else if (cnt == DB_LAST) begin
            cnt     <= '0;
            col_idx <= col_idx + 2'd1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Digit shift register: valid key shifts in, invalid key clears all digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit0     <= 4'd0;
      digit1     <= 4'd0;
      digit2     <= 4'd0;
      key_strobe <= 1'b0;
    end else begin
      key_strobe <= capture_en;
      if (capture_en) begin
        if (key_valid) begin
          digit2 <= digit1;
          digit1 <= digit0;
          digit0 <= key_bcd;
        end else begin
          digit2 <= 4'd0;
          digit1 <= 4'd0;
          digit0 <= 4'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed bench for keypad_entry_ctrl with SCAN_CNT=4, DEBOUNCE_CNT=8.
// A keypad model pulls the pressed key's row low only while its column is
// driven; an override path injects raw row glitches.
module tb_keypad_entry_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [1:0] key_row, key_col;
  logic [3:0] key_bcd;
  logic       key_valid;
  logic [3:0] digit0, digit1, digit2;
  logic       key_strobe;

  logic       pressed = 1'b0;
  logic [1:0] pr = 2'd0, pc = 2'd0;
  logic       ovr_en = 1'b0;
  logic [3:0] ovr_val = 4'hF;

  int n_checks = 0;
  int n_fail   = 0;
  int strobe_cnt = 0;

  always #5 clk = ~clk;

  assign row_in = ovr_en ? ovr_val :
                  (pressed && !col_out[pc]) ? ~(4'b0001 << pr) : 4'hF;

  // Decoder stub: bcd = {row,col}, (3,3) is the invalid/clear key.
  assign key_bcd   = {key_row, key_col};
  assign key_valid = !(key_row == 2'd3 && key_col == 2'd3);

  keypad_entry_ctrl #(.SCAN_CNT(4), .DEBOUNCE_CNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .row_in(row_in), .col_out(col_out),
    .key_row(key_row), .key_col(key_col), .key_bcd(key_bcd),
    .key_valid(key_valid), .digit0(digit0), .digit1(digit1),
    .digit2(digit2), .key_strobe(key_strobe)
  );

  always @(negedge clk) if (key_strobe) strobe_cnt++;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_col_enter(input logic [3:0] col);
    logic [3:0] prev;
    bit ok = 0;
    for (int i = 0; i < 100; i++) begin
      prev = col_out;
      tick();
      if (col_out == col && prev != col) begin ok = 1; break; end
    end
    n_checks++;
    if (!ok) begin
      $display("FAIL col_enter: column %b never entered, col_out=%b", col, col_out);
      n_fail++;
    end
  endtask

  task automatic do_press(input logic [1:0] r, input logic [1:0] c);
    bit seen = 0;
    pr = r; pc = c; pressed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (key_strobe) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen) begin
      $display("FAIL press_strobe: no strobe for key r%0d c%0d", r, c);
      n_fail++;
    end
    tick();
    n_checks++;
    if (key_strobe !== 1'b0) begin
      $display("FAIL strobe_width: key_strobe=%b required 0", key_strobe);
      n_fail++;
    end
    repeat (3) tick();
    pressed = 1'b0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (col_out !== 4'b1110 || key_row !== 2'd0 || key_col !== 2'd0 ||
        digit0 !== 4'd0 || digit1 !== 4'd0 || digit2 !== 4'd0 || key_strobe !== 1'b0) begin
      $display("FAIL reset_values: col=%b row=%0d col_idx=%0d d=%h%h%h stb=%b",
               col_out, key_row, key_col, digit2, digit1, digit0, key_strobe);
      n_fail++;
    end
    rst_n = 1'b1;
  endtask

  task automatic test_idle_scan();
    logic [3:0] exp;
    logic [3:0] one = 4'b0001;
    for (int k = 0; k < 40; k++) begin
      exp = ~(one << ((k / 4) % 4));
      n_checks++;
      if (col_out !== exp) begin
        $display("FAIL idle_scan[%0d]: col_out=%b required %b", k, col_out, exp);
        n_fail++;
      end
      tick();
    end
    n_checks++;
    if (strobe_cnt != 0 || digit0 !== 4'd0 || digit1 !== 4'd0 || digit2 !== 4'd0) begin
      $display("FAIL idle_quiet: strobes=%0d digits=%h%h%h required 0 000",
               strobe_cnt, digit2, digit1, digit0);
      n_fail++;
    end
  endtask

  task automatic test_single_press();
    bit seen = 0;
    int s0 = strobe_cnt;
    pr = 2'd1; pc = 2'd2; pressed = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (key_strobe) begin seen = 1; break; end
    end
    n_checks++;
    if (!seen || key_row !== 2'd1 || key_col !== 2'd2 || digit0 !== 4'h6) begin
      $display("FAIL single_press: seen=%0d row=%0d col=%0d digit0=%h required 1 1 2 6",
               seen, key_row, key_col, digit0);
      n_fail++;
    end
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if (col_out !== 4'b1011 || key_strobe !== 1'b0) begin
        $display("FAIL held_freeze[%0d]: col_out=%b stb=%b required 1011 0", i, col_out, key_strobe);
        n_fail++;
      end
    end
    pressed = 1'b0;
    repeat (12) tick();
    n_checks++;
    if (strobe_cnt - s0 != 1) begin
      $display("FAIL single_press_count: strobes=%0d required 1", strobe_cnt - s0);
      n_fail++;
    end
  endtask

  task automatic test_glitch();
    int s0 = strobe_cnt;
    wait_col_enter(4'b1011);
    ovr_val = 4'b1101; ovr_en = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (col_out !== 4'b1011 || key_row !== 2'd1 || key_col !== 2'd2) begin
      $display("FAIL glitch_detect: col_out=%b row=%0d col=%0d required 1011 1 2",
               col_out, key_row, key_col);
      n_fail++;
    end
    tick();
    ovr_en = 1'b0;
    tick();
    n_checks++;
    if (col_out !== 4'b0111) begin
      $display("FAIL glitch_resume: col_out=%b required 0111", col_out);
      n_fail++;
    end
    repeat (10) tick();
    n_checks++;
    if (strobe_cnt != s0 || digit0 !== 4'h6 || digit1 !== 4'd0 || digit2 !== 4'd0) begin
      $display("FAIL glitch_nochange: strobes=%0d digits=%h%h%h required 0 006",
               strobe_cnt - s0, digit2, digit1, digit0);
      n_fail++;
    end
  endtask

  task automatic test_sequence();
    int s0 = strobe_cnt;
    do_press(2'd0, 2'd1);
    do_press(2'd1, 2'd0);
    do_press(2'd2, 2'd3);
    n_checks++;
    if (digit2 !== 4'h1 || digit1 !== 4'h4 || digit0 !== 4'hB) begin
      $display("FAIL sequence_digits: digits=%h%h%h required 14b", digit2, digit1, digit0);
      n_fail++;
    end
    n_checks++;
    if (strobe_cnt - s0 != 3) begin
      $display("FAIL sequence_count: strobes=%0d required 3", strobe_cnt - s0);
      n_fail++;
    end
  endtask

  task automatic test_clear_key();
    int s0 = strobe_cnt;
    do_press(2'd3, 2'd3);
    n_checks++;
    if (digit2 !== 4'd0 || digit1 !== 4'd0 || digit0 !== 4'd0 || strobe_cnt - s0 != 1) begin
      $display("FAIL clear_key: digits=%h%h%h strobes=%0d required 000 1",
               digit2, digit1, digit0, strobe_cnt - s0);
      n_fail++;
    end
  endtask

  task automatic test_reset_mid_debounce();
    int s0;
    do_press(2'd0, 2'd1);
    n_checks++;
    if (digit0 !== 4'h1) begin
      $display("FAIL pre_reset_digit: digit0=%h required 1", digit0);
      n_fail++;
    end
    s0 = strobe_cnt;
    wait_col_enter(4'b1011);
    pr = 2'd0; pc = 2'd2; pressed = 1'b1;
    repeat (4) tick();
    n_checks++;
    if (col_out !== 4'b1011 || key_col !== 2'd2) begin
      $display("FAIL mid_debounce: col_out=%b col=%0d required 1011 2", col_out, key_col);
      n_fail++;
    end
    repeat (2) tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (col_out !== 4'b1110 || key_row !== 2'd0 || key_col !== 2'd0 || digit0 !== 4'd0 ||
        digit1 !== 4'd0 || digit2 !== 4'd0 || key_strobe !== 1'b0) begin
      $display("FAIL abort_reset: col=%b row=%0d col_idx=%0d d=%h%h%h stb=%b",
               col_out, key_row, key_col, digit2, digit1, digit0, key_strobe);
      n_fail++;
    end
    repeat (3) tick();
    pressed = 1'b0;
    rst_n = 1'b1;
    repeat (20) tick();
    n_checks++;
    if (strobe_cnt != s0 || digit0 !== 4'd0) begin
      $display("FAIL abort_nostrobe: strobes=%0d digit0=%h required 0 0", strobe_cnt - s0, digit0);
      n_fail++;
    end
    do_press(2'd0, 2'd2);
    n_checks++;
    if (digit0 !== 4'h2 || digit1 !== 4'd0 || strobe_cnt - s0 != 1) begin
      $display("FAIL post_reset_press: d1=%h d0=%h strobes=%0d required 0 2 1",
               digit1, digit0, strobe_cnt - s0);
      n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_idle_scan();
    test_single_press();
    test_glitch();
    test_sequence();
    test_clear_key();
    test_reset_mid_debounce();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
